// File: rtl/bus_pkg.sv
// Shared definitions for the bus interconnect arbiter: FSM encoding, slave ids, split record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

   // Default width of the serial slave id shifted in during ADDR.
   localparam int SLAVE_LEN = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_ADDR   = 2'd2,
      ST_ACTIVE = 2'd3
   } arb_state_t;

   localparam logic [1:0] SLAVE_NONE = 2'd0;
   localparam logic [1:0] SLAVE_S1   = 2'd1;
   localparam logic [1:0] SLAVE_S2   = 2'd2;
   localparam logic [1:0] SLAVE_S3   = 2'd3;

   // Master ids double as the m_select encoding.
   localparam logic MST_M1 = 1'b0;
   localparam logic MST_M2 = 1'b1;

   // One parked split: which master was lent away from which slave.
   typedef struct packed {
      logic       vld;
      logic       owner;
      logic [1:0] slave;
   } split_rec_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts data-phase cycles and flags when the owner has held the bus too long.
// Latency: expire is combinational from the count register; count updates one clock after en/clr.
// Backpressure: none; clr has priority over en, count saturates at TIMEOUT-1.
//
// Ports:
//   clk, reset  bus clock, asynchronous active-high reset
//   en          count this cycle (bus in data phase)
//   clr         restart from zero (outside the data phase or on a new data phase)
//   expire      count has reached TIMEOUT-1 while enabled
module arb_timeout_counter #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LAST)) begin
         count <= count + CW'(1);
      end
   end

   assign expire = en && (count == LAST);

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master / three-slave arbiter: grants the bus, shifts in the serial slave id, parks split masters.
// Latency: all outputs registered; every decision is visible one clock after its condition.
// Backpressure: requests are levels held until granted; split slaves stall their master via park/resume.
//
// Ports:
//   clk, reset                 bus clock, asynchronous active-high reset
//   m1_request, m2_request     bus requests (level)
//   m1_slave_sel, m2_slave_sel serial slave id from each master, MSB first, during ADDR
//   trans_done                 one-cycle pulse, current owner finished
//   s1..s3_slave_split_en      slave asks to release its master (level); falling edge resumes
//   m1_grant, m2_grant         bus ownership (mutually exclusive)
//   arbiter_busy               arbitration/addressing in progress or a split is parked
//   bus_busy                   data phase active
//   m_select                   master mux select, 0 = m1, 1 = m2
//   s_select                   slave mux select, 0 = none, 1..3 = s1..s3
//   timeout_err                one-cycle pulse on forced release
module split_bus_arbiter #(
   parameter int SLAVE_LEN = bus_pkg::SLAVE_LEN,
   parameter int TIMEOUT   = 4096,
   parameter bit RR_EN     = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m1_request,
   input  logic       m2_request,
   input  logic       m1_slave_sel,
   input  logic       m2_slave_sel,
   input  logic       trans_done,
   input  logic       s1_slave_split_en,
   input  logic       s2_slave_split_en,
   input  logic       s3_slave_split_en,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic       arbiter_busy,
   output logic       bus_busy,
   output logic       m_select,
   output logic [1:0] s_select,
   output logic       timeout_err
);

   import bus_pkg::*;

   localparam int BW = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;

   arb_state_t           state_q, state_d;
   split_rec_t           rec_q, rec_d;
   logic                 rr_q, rr_d;           // master that wins the next contention
   logic [SLAVE_LEN-1:0] id_q, id_d;
   logic [BW-1:0]        bit_q, bit_d;

   logic       m1_grant_d, m2_grant_d, m_select_d, bus_busy_d, timeout_err_d, arbiter_busy_d;
   logic [1:0] s_select_d;

   logic                 sel_bit;
   logic [SLAVE_LEN-1:0] id_full;
   logic [1:0]           id_2b;
   logic                 id_ok, id_parked;
   logic                 cur_split, park_split, resume_ok;
   logic                 req_m1, req_m2, win;
   logic                 do_release, do_resume, tmo_restart;
   logic                 tmo_en, tmo_clr, tmo_expire;

   // Owner's serial line; m_select already names the owner once GRANT is reached.
   assign sel_bit = m_select ? m2_slave_sel : m1_slave_sel;
   assign id_full = (id_q << 1) | SLAVE_LEN'(sel_bit);
   assign id_2b   = 2'(id_full);
   assign id_ok   = (id_full != '0) && (int'(id_full) <= 3);
   assign id_parked = rec_q.vld && (rec_q.slave == id_2b);

   always_comb begin
      case (s_select)
         SLAVE_S1: cur_split = s1_slave_split_en;
         SLAVE_S2: cur_split = s2_slave_split_en;
         SLAVE_S3: cur_split = s3_slave_split_en;
         default:  cur_split = 1'b0;
      endcase
   end

   always_comb begin
      case (rec_q.slave)
         SLAVE_S1: park_split = s1_slave_split_en;
         SLAVE_S2: park_split = s2_slave_split_en;
         SLAVE_S3: park_split = s3_slave_split_en;
         default:  park_split = 1'b0;
      endcase
   end

   // Parked slave has released its split: the parked owner may come back.
   assign resume_ok = rec_q.vld && !park_split;

   // A parked owner cannot re-arbitrate; it comes back only through resume.
   assign req_m1 = m1_request && !(rec_q.vld && (rec_q.owner == MST_M1));
   assign req_m2 = m2_request && !(rec_q.vld && (rec_q.owner == MST_M2));

   always_comb begin
      state_d       = state_q;
      rec_d         = rec_q;
      rr_d          = rr_q;
      id_d          = id_q;
      bit_d         = bit_q;
      m1_grant_d    = m1_grant;
      m2_grant_d    = m2_grant;
      m_select_d    = m_select;
      s_select_d    = s_select;
      bus_busy_d    = bus_busy;
      timeout_err_d = 1'b0;
      win           = MST_M1;
      do_release    = 1'b0;
      do_resume     = 1'b0;
      tmo_restart   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (resume_ok) begin
               do_resume = 1'b1;
            end else if (req_m1 || req_m2) begin
               if (req_m1 && req_m2) begin
                  win = RR_EN ? rr_q : MST_M1;
               end else begin
                  win = req_m2;
               end
               state_d    = ST_GRANT;
               m1_grant_d = (win == MST_M1);
               m2_grant_d = (win == MST_M2);
               m_select_d = win;
               rr_d       = ~win;
            end
         end

         ST_GRANT: begin
            state_d = ST_ADDR;
            id_d    = '0;
            bit_d   = '0;
         end

         ST_ADDR: begin
            id_d  = id_full;
            bit_d = bit_q + BW'(1);
            if (bit_q == BW'(SLAVE_LEN - 1)) begin
               // Invalid id, or a slave still holding a parked split, aborts the grant.
               if (id_ok && !id_parked) begin
                  state_d    = ST_ACTIVE;
                  s_select_d = id_2b;
                  bus_busy_d = 1'b1;
               end else begin
                  do_release = 1'b1;
               end
            end
         end

         ST_ACTIVE: begin
            if (trans_done) begin
               // A pending resume goes straight into the next data phase.
               if (resume_ok) begin
                  do_resume   = 1'b1;
                  tmo_restart = 1'b1;
               end else begin
                  do_release = 1'b1;
               end
            end else if (tmo_expire) begin
               do_release    = 1'b1;
               timeout_err_d = 1'b1;
            end else if (cur_split && !rec_q.vld) begin
               rec_d      = '{vld: 1'b1, owner: m_select, slave: s_select};
               do_release = 1'b1;
            end
         end

         default: begin
            do_release = 1'b1;
         end
      endcase

      if (do_release) begin
         state_d    = ST_IDLE;
         m1_grant_d = 1'b0;
         m2_grant_d = 1'b0;
         m_select_d = MST_M1;
         s_select_d = SLAVE_NONE;
         bus_busy_d = 1'b0;
      end

      if (do_resume) begin
         state_d    = ST_ACTIVE;
         m1_grant_d = (rec_q.owner == MST_M1);
         m2_grant_d = (rec_q.owner == MST_M2);
         m_select_d = rec_q.owner;
         s_select_d = rec_q.slave;
         bus_busy_d = 1'b1;
         rec_d      = '0;
      end

      arbiter_busy_d = ((state_d != ST_IDLE) && (state_d != ST_ACTIVE)) || rec_d.vld;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rec_q        <= '0;
         rr_q         <= MST_M1;
         id_q         <= '0;
         bit_q        <= '0;
         m1_grant     <= 1'b0;
         m2_grant     <= 1'b0;
         m_select     <= 1'b0;
         s_select     <= SLAVE_NONE;
         bus_busy     <= 1'b0;
         timeout_err  <= 1'b0;
         arbiter_busy <= 1'b0;
      end else begin
         state_q      <= state_d;
         rec_q        <= rec_d;
         rr_q         <= rr_d;
         id_q         <= id_d;
         bit_q        <= bit_d;
         m1_grant     <= m1_grant_d;
         m2_grant     <= m2_grant_d;
         m_select     <= m_select_d;
         s_select     <= s_select_d;
         bus_busy     <= bus_busy_d;
         timeout_err  <= timeout_err_d;
         arbiter_busy <= arbiter_busy_d;
      end
   end

   // Counter runs only in the data phase and restarts on every entry to it.
   assign tmo_en  = (state_q == ST_ACTIVE);
   assign tmo_clr = (state_q != ST_ACTIVE) || tmo_restart;

   arb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .en     (tmo_en),
      .clr    (tmo_clr),
      .expire (tmo_expire)
   );

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed bench for split_bus_arbiter: a round-robin instance (TIMEOUT=16) and a fixed-priority one.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_split_bus_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic m1_request = 1'b0, m2_request = 1'b0;
   logic m1_slave_sel = 1'b0, m2_slave_sel = 1'b0;
   logic trans_done = 1'b0;
   logic s1_split = 1'b0, s2_split = 1'b0, s3_split = 1'b0;

   logic       m1_grant, m2_grant, arbiter_busy, bus_busy, m_select, timeout_err;
   logic [1:0] s_select;
   logic       d0_m1_grant, d0_m2_grant, d0_arbiter_busy, d0_bus_busy, d0_m_select, d0_timeout_err;
   logic [1:0] d0_s_select;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   split_bus_arbiter #(.SLAVE_LEN(2), .TIMEOUT(16), .RR_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .m1_request(m1_request), .m2_request(m2_request),
      .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
      .trans_done(trans_done),
      .s1_slave_split_en(s1_split), .s2_slave_split_en(s2_split), .s3_slave_split_en(s3_split),
      .m1_grant(m1_grant), .m2_grant(m2_grant), .arbiter_busy(arbiter_busy),
      .bus_busy(bus_busy), .m_select(m_select), .s_select(s_select), .timeout_err(timeout_err)
   );

   split_bus_arbiter #(.SLAVE_LEN(2), .TIMEOUT(16), .RR_EN(1'b0)) dut_fixed (
      .clk(clk), .reset(reset),
      .m1_request(m1_request), .m2_request(m2_request),
      .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
      .trans_done(trans_done),
      .s1_slave_split_en(s1_split), .s2_slave_split_en(s2_split), .s3_slave_split_en(s3_split),
      .m1_grant(d0_m1_grant), .m2_grant(d0_m2_grant), .arbiter_busy(d0_arbiter_busy),
      .bus_busy(d0_bus_busy), .m_select(d0_m_select), .s_select(d0_s_select),
      .timeout_err(d0_timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   // Called in the GRANT cycle; returns in the cycle after the ADDR decision.
   task automatic send_id(input logic [1:0] id);
      tick();
      m1_slave_sel = id[1];
      m2_slave_sel = id[1];
      tick();
      m1_slave_sel = id[0];
      m2_slave_sel = id[0];
      tick();
      m1_slave_sel = 1'b0;
      m2_slave_sel = 1'b0;
   endtask

   task automatic pulse_done();
      trans_done = 1'b1;
      tick();
      trans_done = 1'b0;
   endtask

   // m1 reaches s2, then s2 splits; returns in IDLE with the split parked.
   task automatic park_m1_s2();
      m1_request = 1'b1;
      tick();
      m1_request = 1'b0;
      send_id(2'b10);
      s2_split = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      do_reset();
      chk("rst_m1_grant", m1_grant, 0);
      chk("rst_m2_grant", m2_grant, 0);
      chk("rst_arb_busy", arbiter_busy, 0);
      chk("rst_bus_busy", bus_busy, 0);
      chk("rst_s_select", s_select, 0);
      chk("rst_tmo_err", timeout_err, 0);

      // 1: single m2 transaction to s2
      m2_request = 1'b1;
      tick();
      chk("t1_m2_grant_c1", m2_grant, 1);
      chk("t1_m1_grant_c1", m1_grant, 0);
      chk("t1_m_select_c1", m_select, 1);
      chk("t1_arb_busy_c1", arbiter_busy, 1);
      m2_request = 1'b0;
      send_id(2'b10);
      chk("t1_s_select_c4", s_select, 2);
      chk("t1_bus_busy_c4", bus_busy, 1);
      chk("t1_arb_busy_c4", arbiter_busy, 0);
      repeat (4) tick();
      pulse_done();
      chk("t1_m2_grant_done", m2_grant, 0);
      chk("t1_s_select_done", s_select, 0);
      chk("t1_bus_busy_done", bus_busy, 0);
      chk("t1_m_select_done", m_select, 0);
      // id 0 aborts the grant
      m2_request = 1'b1;
      tick();
      m2_request = 1'b0;
      send_id(2'b00);
      chk("t1_id0_grant", m2_grant, 0);
      chk("t1_id0_bus_busy", bus_busy, 0);
      chk("t1_id0_arb_busy", arbiter_busy, 0);

      // 2: contention, round-robin vs fixed priority
      do_reset();
      m1_request = 1'b1;
      m2_request = 1'b1;
      tick();
      chk("t2_rr_first_m1", m1_grant, 1);
      chk("t2_rr_first_m2", m2_grant, 0);
      chk("t2_fx_first_m1", d0_m1_grant, 1);
      send_id(2'b01);
      chk("t2_rr_s_select", s_select, 1);
      pulse_done();
      chk("t2_rr_idle_m1", m1_grant, 0);
      tick();
      chk("t2_rr_second_m2", m2_grant, 1);
      chk("t2_rr_second_m1", m1_grant, 0);
      chk("t2_rr_second_msel", m_select, 1);
      chk("t2_fx_second_m1", d0_m1_grant, 1);
      chk("t2_fx_second_m2", d0_m2_grant, 0);
      m1_request = 1'b0;
      m2_request = 1'b0;
      send_id(2'b11);
      chk("t2_rr_s_select2", s_select, 3);
      chk("t2_fx_s_select2", d0_s_select, 3);
      pulse_done();

      // 3: split parked, m2 lent the bus, resume from IDLE without ADDR
      do_reset();
      park_m1_s2();
      chk("t3_park_m1_grant", m1_grant, 0);
      chk("t3_park_s_select", s_select, 0);
      chk("t3_park_bus_busy", bus_busy, 0);
      chk("t3_park_arb_busy", arbiter_busy, 1);
      m1_request = 1'b1;          // parked owner's request must be ignored
      m2_request = 1'b1;
      tick();
      chk("t3_m2_grant", m2_grant, 1);
      chk("t3_m1_ignored", m1_grant, 0);
      m1_request = 1'b0;
      m2_request = 1'b0;
      send_id(2'b11);
      chk("t3_m2_s_select", s_select, 3);
      chk("t3_m2_arb_busy", arbiter_busy, 1);
      pulse_done();
      chk("t3_m2_done_grant", m2_grant, 0);
      chk("t3_m2_done_arb_busy", arbiter_busy, 1);
      s2_split = 1'b0;
      tick();
      chk("t3_resume_m1_grant", m1_grant, 1);
      chk("t3_resume_s_select", s_select, 2);
      chk("t3_resume_bus_busy", bus_busy, 1);
      chk("t3_resume_arb_busy", arbiter_busy, 0);
      pulse_done();
      chk("t3_final_m1_grant", m1_grant, 0);

      // 3b: split falls while m2 is in flight; resume right after its trans_done
      do_reset();
      park_m1_s2();
      m2_request = 1'b1;
      tick();
      m2_request = 1'b0;
      send_id(2'b11);
      s2_split = 1'b0;
      m2_request = 1'b1;          // competing new request must lose to the resume
      tick();
      chk("t3b_m2_still_owner", m2_grant, 1);
      pulse_done();
      chk("t3b_resume_m1", m1_grant, 1);
      chk("t3b_resume_m2_off", m2_grant, 0);
      chk("t3b_resume_s_select", s_select, 2);
      m2_request = 1'b0;
      pulse_done();

      // 4: m2 addresses the parked slave
      do_reset();
      park_m1_s2();
      m2_request = 1'b1;
      tick();
      m2_request = 1'b0;
      send_id(2'b10);
      chk("t4_m2_dropped", m2_grant, 0);
      chk("t4_bus_busy", bus_busy, 0);
      chk("t4_arb_busy_parked", arbiter_busy, 1);
      s2_split = 1'b0;
      tick();
      chk("t4_record_m1", m1_grant, 1);
      chk("t4_record_slave", s_select, 2);
      pulse_done();

      // 5: timeout after 16 ACTIVE cycles
      do_reset();
      m1_request = 1'b1;
      tick();
      m1_request = 1'b0;
      send_id(2'b01);
      repeat (15) tick();
      chk("t5_still_busy", bus_busy, 1);
      chk("t5_no_err_yet", timeout_err, 0);
      tick();
      chk("t5_tmo_err", timeout_err, 1);
      chk("t5_tmo_grant", m1_grant, 0);
      chk("t5_tmo_bus_busy", bus_busy, 0);
      tick();
      chk("t5_err_pulse", timeout_err, 0);

      // 6: asynchronous reset mid-ACTIVE and mid-split
      do_reset();
      m2_request = 1'b1;
      tick();
      m2_request = 1'b0;
      send_id(2'b01);
      reset = 1'b1;
      #1;
      chk("t6_act_m2_grant", m2_grant, 0);
      chk("t6_act_bus_busy", bus_busy, 0);
      chk("t6_act_m_select", m_select, 0);
      chk("t6_act_s_select", s_select, 0);
      #1;
      reset = 1'b0;
      tick();
      park_m1_s2();
      reset = 1'b1;
      #1;
      chk("t6_split_arb_busy", arbiter_busy, 0);
      #1;
      reset = 1'b0;
      s2_split = 1'b0;
      repeat (3) tick();
      chk("t6_no_resume_grant", m1_grant, 0);
      chk("t6_no_resume_busy", bus_busy, 0);
      chk("t6_no_resume_sel", s_select, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
